// File: rtl/asram_pkg.sv
// rtl/asram_pkg.sv - shared FSM state type, wait-counter width and beat helpers for asram_ctrl
// Ports: none (package).
//   beat_en(sel, beat, bw) : 1 when any byte select belonging to SRAM beat 'beat' is set
//   next_beat(sel, cur)    : lowest enabled beat index >= cur in per-beat mask 'sel'; 4 means none left
package asram_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_ACK
  } state_t;

  function automatic logic beat_en(input logic [3:0] sel, input int beat, input int bw);
    logic en;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (((i / bw) == beat) && sel[i]) en = 1'b1;
    end
    return en;
  endfunction

  // Scans downwards so the last hit is the lowest qualifying index.
  function automatic logic [2:0] next_beat(input logic [3:0] sel, input logic [2:0] cur);
    logic [2:0] nb;
    nb = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= int'(cur)) && sel[i]) nb = 3'(i);
    end
    return nb;
  endfunction

endpackage

// File: rtl/asram_wait_cnt.sv
// rtl/asram_wait_cnt.sv - loadable down-counter with zero flag, times the SRAM access phase
// Ports:
//   clk      in  clock
//   rst_n    in  synchronous active-low reset
//   load     in  load load_val this cycle
//   load_val in  WAIT_W value to load
//   dec      in  decrement (saturates at zero)
//   zero     out count is zero
module asram_wait_cnt
  import asram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/asram_ctrl.sv
// rtl/asram_ctrl.sv - Wishbone classic slave splitting 32-bit accesses into 8/16-bit async SRAM beats
// Ports:
//   wb_clk_i, wb_rst_i (sync, active-low)      clock and reset
//   wb_adr_i/dat_i/sel_i/we_i/stb_i/cyc_i      Wishbone classic request
//   wb_dat_o, wb_ack_o                          registered read data, single-cycle ack
//   sram_dq (tri), sram_addr, sram_be_n         SRAM data, word address, active-low byte lanes
//   sram_ce_n, sram_oe_n, sram_we_n             registered active-low strobes
module asram_ctrl
  import asram_pkg::*;
#(
  parameter  int SRAM_DW = 16,
  parameter  int WB_AW   = 19,
  parameter  int RD_WAIT = 1,
  parameter  int WR_WAIT = 1,
  localparam int NB      = 32 / SRAM_DW,
  localparam int BW      = SRAM_DW / 8,
  localparam int SRAM_AW = WB_AW - $clog2(BW)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [BW-1:0]      sram_be_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int BEAT_W = $clog2(NB);

  state_t             state;
  logic [WB_AW-1:2]   adr_q;
  logic               we_q;
  logic [3:0]         sel_q;
  logic [31:0]        dat_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               abort_q;
  logic [SRAM_DW-1:0] dq_out;
  logic               dq_oe;

  logic [3:0]         in_mask, q_mask;
  logic [2:0]         first_beat, nxt_beat, tgt;
  logic [WB_AW-1:2]   src_adr;
  logic               src_we;
  logic [3:0]         src_sel;
  logic [31:0]        src_dat;
  logic [BEAT_W-1:0]  tgt_beat;
  logic [4:0]         tgt_dbase, tgt_sbase, rd_base;
  logic               accept, launch, cnt_zero;
  logic               unused_bits;

  assign sram_dq     = dq_oe ? dq_out : 'z;
  assign unused_bits = ^{wb_adr_i[1:0], tgt};

  // A beat is launched either from IDLE (request fields taken straight off
  // the bus) or from HOLD (fields from the latched request).
  always_comb begin
    in_mask = '0;
    q_mask  = '0;
    for (int b = 0; b < NB; b++) begin
      in_mask[b] = beat_en(wb_sel_i, b, BW);
      q_mask[b]  = beat_en(sel_q, b, BW);
    end
    first_beat = next_beat(in_mask, 3'd0);
    nxt_beat   = next_beat(q_mask, 3'(beat_q) + 3'd1);
    accept     = (state == S_IDLE) && wb_cyc_i && wb_stb_i;
    if (state == S_IDLE) begin
      src_adr = wb_adr_i[WB_AW-1:2];
      src_we  = wb_we_i;
      src_sel = wb_sel_i;
      src_dat = wb_dat_i;
      tgt     = first_beat;
    end else begin
      src_adr = adr_q;
      src_we  = we_q;
      src_sel = sel_q;
      src_dat = dat_q;
      tgt     = nxt_beat;
    end
    tgt_beat  = tgt[BEAT_W-1:0];
    tgt_dbase = 5'(tgt_beat) * 5'(SRAM_DW);
    tgt_sbase = 5'(tgt_beat) * 5'(BW);
    rd_base   = 5'(beat_q) * 5'(SRAM_DW);
    launch    = (accept && !first_beat[2]) ||
                ((state == S_HOLD) && !abort_q && wb_cyc_i && !nxt_beat[2]);
  end

  asram_wait_cnt u_wait (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .load     (state == S_SETUP),
    .load_val (we_q ? WAIT_W'(WR_WAIT) : WAIT_W'(RD_WAIT)),
    .dec      (state == S_ACCESS),
    .zero     (cnt_zero)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state     <= S_IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      beat_q    <= '0;
      abort_q   <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      sram_addr <= '0;
      sram_be_n <= '1;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            adr_q    <= wb_adr_i[WB_AW-1:2];
            we_q     <= wb_we_i;
            sel_q    <= wb_sel_i;
            dat_q    <= wb_dat_i;
            abort_q  <= 1'b0;
            wb_dat_o <= '0;
            if (first_beat[2]) begin
              state    <= S_ACK;
              wb_ack_o <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          abort_q   <= abort_q | ~wb_cyc_i;
          sram_we_n <= ~we_q;
          state     <= S_ACCESS;
        end
        S_ACCESS: begin
          // An abort is only remembered here; the access runs to full length
          // so a we_n pulse is never cut short.
          abort_q <= abort_q | ~wb_cyc_i;
          if (cnt_zero) begin
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!we_q) wb_dat_o[rd_base +: SRAM_DW] <= sram_dq;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!launch) begin
            sram_ce_n <= 1'b1;
            sram_be_n <= '1;
            dq_oe     <= 1'b0;
            if (abort_q || !wb_cyc_i) begin
              state <= S_IDLE;
            end else begin
              state    <= S_ACK;
              wb_ack_o <= 1'b1;
            end
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (launch) begin
        state     <= S_SETUP;
        beat_q    <= tgt_beat;
        sram_addr <= {src_adr, tgt_beat};
        sram_be_n <= ~src_sel[tgt_sbase +: BW];
        sram_ce_n <= 1'b0;
        sram_oe_n <= src_we;
        sram_we_n <= 1'b1;
        dq_out    <= src_dat[tgt_dbase +: SRAM_DW];
        dq_oe     <= src_we;
      end
    end
  end

endmodule

// File: tb/tb_asram_ctrl.sv
// tb/tb_asram_ctrl.sv - directed self-checking bench for asram_ctrl (16-bit and 8-bit instances)
// Ports: none (top-level bench).
module tb_asram_ctrl;

  localparam int AW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // 16-bit instance: RD_WAIT=1, WR_WAIT=2
  logic [AW-1:0] adr16;
  logic [31:0]   dati16, dato16;
  logic [3:0]    sel16;
  logic          we16, stb16, cyc16, ack16;
  wire  [15:0]   dq16;
  logic [17:0]   addr16;
  logic [1:0]    ben16;
  logic          ce16, oe16, wen16;

  asram_ctrl #(.SRAM_DW(16), .WB_AW(AW), .RD_WAIT(1), .WR_WAIT(2)) u16 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr16), .wb_dat_i(dati16), .wb_sel_i(sel16),
    .wb_we_i(we16), .wb_stb_i(stb16), .wb_cyc_i(cyc16), .wb_dat_o(dato16), .wb_ack_o(ack16),
    .sram_dq(dq16), .sram_addr(addr16), .sram_be_n(ben16), .sram_ce_n(ce16),
    .sram_oe_n(oe16), .sram_we_n(wen16)
  );

  // 8-bit instance: RD_WAIT=1, WR_WAIT=1
  logic [AW-1:0] adr8;
  logic [31:0]   dati8, dato8;
  logic [3:0]    sel8;
  logic          we8, stb8, cyc8, ack8;
  wire  [7:0]    dq8;
  logic [18:0]   addr8;
  logic [0:0]    ben8;
  logic          ce8, oe8, wen8;

  asram_ctrl #(.SRAM_DW(8), .WB_AW(AW), .RD_WAIT(1), .WR_WAIT(1)) u8 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr8), .wb_dat_i(dati8), .wb_sel_i(sel8),
    .wb_we_i(we8), .wb_stb_i(stb8), .wb_cyc_i(cyc8), .wb_dat_o(dato8), .wb_ack_o(ack8),
    .sram_dq(dq8), .sram_addr(addr8), .sram_be_n(ben8), .sram_ce_n(ce8),
    .sram_oe_n(oe8), .sram_we_n(wen8)
  );

  // SRAM models: contents reload a known pattern whenever reset is low.
  function automatic logic [15:0] init16(input int i);
    return {8'(i) ^ 8'hA0, 8'(i)};
  endfunction
  function automatic logic [7:0] init8(input int i);
    return 8'(i) ^ 8'h3C;
  endfunction

  logic [15:0] mem16 [0:63];
  logic [7:0]  mem8  [0:127];

  assign dq16 = (!ce16 && !oe16) ? mem16[addr16[5:0]] : 16'bz;
  assign dq8  = (!ce8 && !oe8) ? mem8[addr8[6:0]] : 8'bz;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem16[i] <= init16(i);
      for (int i = 0; i < 128; i++) mem8[i] <= init8(i);
    end else begin
      if (!ce16 && !wen16) begin
        for (int i = 0; i < 2; i++)
          if (!ben16[i]) mem16[addr16[5:0]][i*8 +: 8] <= dq16[i*8 +: 8];
      end
      if (!ce8 && !wen8 && !ben8[0]) mem8[addr8[6:0]] <= dq8;
    end
  end

  // One transfer on the 16-bit instance; cycle 0 is the cycle stb is first sampled.
  task automatic xfer16(input logic [AW-1:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, output int ack_c, output int we_low,
                        output int ce_low, output logic [31:0] rdat,
                        output logic [17:0] wr_addr, output logic [1:0] wr_ben);
    @(negedge clk);
    adr16 = adr; we16 = we; sel16 = sel; dati16 = dat; cyc16 = 1'b1; stb16 = 1'b1;
    ack_c = -1; we_low = 0; ce_low = 0; rdat = '0; wr_addr = '0; wr_ben = '1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!ce16) ce_low++;
      if (!wen16) begin
        we_low++;
        wr_addr = addr16;
        wr_ben  = ben16;
      end
      if (ack16) begin
        ack_c = c;
        rdat  = dato16;
        break;
      end
    end
    cyc16 = 1'b0; stb16 = 1'b0;
  endtask

  task automatic xfer8(input logic [AW-1:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, output int ack_c, output int we_low,
                       output logic [31:0] rdat);
    @(negedge clk);
    adr8 = adr; we8 = we; sel8 = sel; dati8 = dat; cyc8 = 1'b1; stb8 = 1'b1;
    ack_c = -1; we_low = 0; rdat = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!wen8) we_low++;
      if (ack8) begin
        ack_c = c;
        rdat  = dato8;
        break;
      end
    end
    cyc8 = 1'b0; stb8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adr16 = '0; dati16 = '0; sel16 = '0; we16 = 1'b0; stb16 = 1'b0; cyc16 = 1'b0;
    adr8  = '0; dati8  = '0; sel8  = '0; we8  = 1'b0; stb8  = 1'b0; cyc8  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({ack16, ce16, oe16, wen16} !== 4'b0111) begin n_fail++;
      $display("FAIL rst16_strobes: got %b expected 0111", {ack16, ce16, oe16, wen16}); end
    n_checks++; if (ben16 !== 2'b11) begin n_fail++;
      $display("FAIL rst16_be_n: got %b expected 11", ben16); end
    n_checks++; if (addr16 !== 18'd0) begin n_fail++;
      $display("FAIL rst16_addr: got %h expected 0", addr16); end
    n_checks++; if (dato16 !== 32'd0) begin n_fail++;
      $display("FAIL rst16_dat_o: got %h expected 0", dato16); end
    n_checks++; if (u16.dq_oe !== 1'b0) begin n_fail++;
      $display("FAIL rst16_dq_drive: got %b expected 0", u16.dq_oe); end
    n_checks++; if ({ack8, ce8, oe8, wen8, ben8} !== 5'b01111) begin n_fail++;
      $display("FAIL rst8_strobes: got %b expected 01111", {ack8, ce8, oe8, wen8, ben8}); end
    n_checks++; if (dato8 !== 32'd0 || addr8 !== 19'd0) begin n_fail++;
      $display("FAIL rst8_dat_addr: got %h/%h expected 0/0", dato8, addr8); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read16();
    int ack_c, wl, cl; logic [31:0] rd; logic [17:0] wa; logic [1:0] wb;
    xfer16(19'h00010, 1'b0, 4'b1111, '0, ack_c, wl, cl, rd, wa, wb);
    n_checks++; if (ack_c !== 9) begin n_fail++;
      $display("FAIL rd16_ack_cycle: got %0d expected 9", ack_c); end
    n_checks++; if (rd !== 32'hA909_A808) begin n_fail++;
      $display("FAIL rd16_data: got %h expected a909a808", rd); end
    n_checks++; if (cl !== 8 || wl !== 0) begin n_fail++;
      $display("FAIL rd16_strobe_cycles: got ce %0d we %0d expected ce 8 we 0", cl, wl); end
    xfer16(19'h00010, 1'b0, 4'b0010, '0, ack_c, wl, cl, rd, wa, wb);
    n_checks++; if (ack_c !== 5) begin n_fail++;
      $display("FAIL rd16_part_ack: got %0d expected 5", ack_c); end
    n_checks++; if (rd !== 32'h0000_A808) begin n_fail++;
      $display("FAIL rd16_part_data: got %h expected 0000a808", rd); end
  endtask

  task automatic test_sel_zero();
    int ack_c, wl, cl; logic [31:0] rd; logic [17:0] wa; logic [1:0] wb;
    xfer16(19'h00010, 1'b0, 4'b1111, '0, ack_c, wl, cl, rd, wa, wb);
    xfer16(19'h00010, 1'b0, 4'b0000, '0, ack_c, wl, cl, rd, wa, wb);
    n_checks++; if (ack_c !== 1) begin n_fail++;
      $display("FAIL sel0_ack_cycle: got %0d expected 1", ack_c); end
    n_checks++; if (rd !== 32'd0) begin n_fail++;
      $display("FAIL sel0_data: got %h expected 0", rd); end
    n_checks++; if (cl !== 0) begin n_fail++;
      $display("FAIL sel0_ce_cycles: got %0d expected 0", cl); end
  endtask

  task automatic test_write16();
    int ack_c, wl, cl; logic [31:0] rd; logic [17:0] wa; logic [1:0] wb;
    xfer16(19'h00020, 1'b1, 4'b1100, 32'hA5A5_1234, ack_c, wl, cl, rd, wa, wb);
    n_checks++; if (ack_c !== 6) begin n_fail++;
      $display("FAIL wr16_ack_cycle: got %0d expected 6", ack_c); end
    n_checks++; if (wl !== 3) begin n_fail++;
      $display("FAIL wr16_we_low: got %0d expected 3", wl); end
    n_checks++; if (wa !== 18'h00011 || wb !== 2'b00) begin n_fail++;
      $display("FAIL wr16_addr_be: got %h/%b expected 00011/00", wa, wb); end
    n_checks++; if (mem16[17] !== 16'hA5A5) begin n_fail++;
      $display("FAIL wr16_mem_hi: got %h expected a5a5", mem16[17]); end
    n_checks++; if (mem16[16] !== 16'hB010) begin n_fail++;
      $display("FAIL wr16_mem_lo_skipped: got %h expected b010", mem16[16]); end
  endtask

  task automatic test_sram8();
    int ack_c, wl; logic [31:0] rd;
    xfer8(19'h00040, 1'b1, 4'b0101, 32'hDDCC_BBAA, ack_c, wl, rd);
    n_checks++; if (ack_c !== 9) begin n_fail++;
      $display("FAIL wr8_ack_cycle: got %0d expected 9", ack_c); end
    n_checks++; if (wl !== 4) begin n_fail++;
      $display("FAIL wr8_we_low: got %0d expected 4", wl); end
    n_checks++; if ({mem8[67], mem8[66], mem8[65], mem8[64]} !== 32'h7FCC_7DAA) begin n_fail++;
      $display("FAIL wr8_mem: got %h expected 7fcc7daa",
               {mem8[67], mem8[66], mem8[65], mem8[64]}); end
    xfer8(19'h00040, 1'b0, 4'b0110, '0, ack_c, wl, rd);
    n_checks++; if (ack_c !== 9) begin n_fail++;
      $display("FAIL rd8_ack_cycle: got %0d expected 9", ack_c); end
    n_checks++; if (rd !== 32'h00CC_7D00) begin n_fail++;
      $display("FAIL rd8_data: got %h expected 00cc7d00", rd); end
  endtask

  task automatic test_reset_mid_write();
    int ack_c, wl, cl, acks; logic [31:0] rd; logic [17:0] wa; logic [1:0] wb;
    bit seen;
    @(negedge clk);
    adr16 = 19'h00030; we16 = 1'b1; sel16 = 4'b1111; dati16 = 32'h1111_2222;
    cyc16 = 1'b1; stb16 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (!wen16) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++;
      $display("FAIL rstmid_we_started: got no we_n pulse expected one within 10 cycles"); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({wen16, ce16, oe16} !== 3'b111) begin n_fail++;
      $display("FAIL rstmid_strobes: got %b expected 111", {wen16, ce16, oe16}); end
    n_checks++; if (u16.dq_oe !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_dq_drive: got %b expected 0", u16.dq_oe); end
    rst_n = 1'b1; cyc16 = 1'b0; stb16 = 1'b0;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack16) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++;
      $display("FAIL rstmid_no_ack: got %0d acks expected 0", acks); end
    xfer16(19'h00010, 1'b0, 4'b1111, '0, ack_c, wl, cl, rd, wa, wb);
    n_checks++; if (ack_c !== 9 || rd !== 32'hA909_A808) begin n_fail++;
      $display("FAIL rstmid_next_xfer: got ack %0d data %h expected ack 9 data a909a808", ack_c, rd); end
  endtask

  task automatic test_abort();
    int ack_c, wl, cl, ce_low, acks; logic [31:0] rd; logic [17:0] wa; logic [1:0] wb;
    bit beat1;
    @(negedge clk);
    adr16 = 19'h00010; we16 = 1'b0; sel16 = 4'b1111; cyc16 = 1'b1; stb16 = 1'b1;
    ce_low = 0; acks = 0; beat1 = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (!ce16) ce_low++;
      if (!ce16 && addr16 == 18'd9) beat1 = 1'b1;
      if (ack16) acks++;
      if (c == 2) begin cyc16 = 1'b0; stb16 = 1'b0; end
    end
    n_checks++; if (ce_low !== 4) begin n_fail++;
      $display("FAIL abort_ce_cycles: got %0d expected 4", ce_low); end
    n_checks++; if (acks !== 0) begin n_fail++;
      $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
    n_checks++; if (beat1) begin n_fail++;
      $display("FAIL abort_beat1_strobed: got 1 expected 0"); end
    xfer16(19'h00010, 1'b0, 4'b0000, '0, ack_c, wl, cl, rd, wa, wb);
    n_checks++; if (ack_c !== 1) begin n_fail++;
      $display("FAIL abort_back_idle: got ack %0d expected 1", ack_c); end
  endtask

  task automatic test_back_to_back();
    int ack1, ack2; logic [31:0] rd2; logic ce_gap;
    @(negedge clk);
    adr16 = 19'h00010; we16 = 1'b0; sel16 = 4'b1111; cyc16 = 1'b1; stb16 = 1'b1;
    ack1 = -1; ack2 = -1; rd2 = '0; ce_gap = 1'b0;
    for (int c = 1; c <= 30 && ack2 < 0; c++) begin
      @(negedge clk);
      if (c == ack1 + 1 && ack1 > 0) ce_gap = ce16;
      if (ack16) begin
        if (ack1 < 0) begin
          ack1 = c;
          adr16 = 19'h00014;
        end else begin
          ack2 = c;
          rd2 = dato16;
        end
      end
    end
    cyc16 = 1'b0; stb16 = 1'b0;
    n_checks++; if (ack1 !== 9) begin n_fail++;
      $display("FAIL b2b_ack1_cycle: got %0d expected 9", ack1); end
    n_checks++; if (ack2 !== 19) begin n_fail++;
      $display("FAIL b2b_ack2_cycle: got %0d expected 19", ack2); end
    n_checks++; if (rd2 !== 32'hAB0B_AA0A) begin n_fail++;
      $display("FAIL b2b_data: got %h expected ab0baa0a", rd2); end
    n_checks++; if (ce_gap !== 1'b1) begin n_fail++;
      $display("FAIL b2b_ce_gap: got %b expected 1", ce_gap); end
  endtask

  initial begin
    test_reset();
    test_read16();
    test_sel_zero();
    test_write16();
    test_sram8();
    test_reset_mid_write();
    test_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/asram_ctrl.md
# asram_ctrl

Parametrised Wishbone classic slave driving an asynchronous SRAM of 8- or 16-bit data width. It is the successor to the fixed 16-bit SRAM bridge. It splits each 32-bit Wishbone access into SRAM beats and skips beats whose byte selects are all zero. It generates programmable ce/oe/we timing with setup, wait and hold phases, and returns one registered ack per Wishbone transfer. It sits between the system Wishbone interconnect and the board SRAM pins.

## Interface
Parameters:
- SRAM_DW, 16: SRAM data width, 8 or 16.
- WB_AW, 19: Wishbone byte-address width.
- RD_WAIT, 1: extra read access cycles, 0..15.
- WR_WAIT, 1: extra we_n-low cycles, 0..15.
- Derived: NB = 32/SRAM_DW beats; BW = SRAM_DW/8 byte lanes per beat; SRAM_AW = WB_AW − log2(BW).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-low.
- wb_adr_i  in  WB_AW  byte address; bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_we_i, wb_stb_i, wb_cyc_i  in  1  Wishbone classic controls.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  single-cycle ack.
- sram_dq  inout  SRAM_DW  data; driven only while a write beat is active, otherwise hi-Z.
- sram_addr  out  SRAM_AW  word address.
- sram_be_n  out  BW  byte-lane enables, active-low.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low strobes.

## Operation
- FSM states:
  - IDLE: on cyc&stb, latch adr, we, sel and dat_i, and clear wb_dat_o's read buffer to 0. Go to the first enabled beat in SETUP. If sel==0, go directly to ACK.
  - SETUP (1 cycle): sram_addr = {adr[WB_AW-1:2], beat}. sram_be_n = ~sel lanes of the current beat. ce_n=0. oe_n=we. we_n=1. A write drives dq.
  - ACCESS (RD_WAIT+1 or WR_WAIT+1 cycles, counted down by the wait counter): a write holds we_n=0. A read captures sram_dq into buffer lane [beat*SRAM_DW +: SRAM_DW] on the last ACCESS cycle.
  - HOLD (1 cycle): we_n=1 and oe_n=1. ce_n, addr and write dq are held. Then go to SETUP for the next enabled beat, or to ACK.
  - ACK (1 cycle): wb_ack_o=1; go to IDLE.
- Beat order is ascending; beat 0 is bits [SRAM_DW-1:0] at the lower SRAM address (little-endian).
- Read lanes of skipped beats return 0. Unselected bytes inside an executed beat return the SRAM contents.
- Abort: if cyc_i goes low in SETUP or ACCESS, the current beat finishes through HOLD. The FSM then returns to IDLE with no ack, and remaining beats are skipped. A we_n pulse is never shortened.
- All SRAM outputs are registered. ce_n is high in IDLE and ACK; it is never tied low.

## Timing
- Reset values: wb_ack_o=0, wb_dat_o=0, ce_n=oe_n=we_n=1, sram_be_n all 1, sram_addr=0, dq hi-Z, state IDLE.
- Reset asserted mid-beat: at the next edge all strobes are high and dq is hi-Z. No ack is issued.
- Latency: stb is sampled in cycle 0. Each executed beat costs 3+W cycles, where W = RD_WAIT or WR_WAIT. Ack is issued in cycle 1 + Σ(3+W) over executed beats. For sel==0, ack is in cycle 1.
- Back-to-back: stb still high in the cycle after ACK starts a new transfer. There is a 1-cycle minimum ce_n-high gap between transfers.
- Read data is stable on wb_dat_o from ACK until the next IDLE accept.

## Structure
- Package asram_pkg holds:
  - the state enum;
  - the function beat_en(sel, beat, BW);
  - the function next_beat(sel, cur);
  - the constant WAIT_W = 4.
- Sub-module asram_wait_cnt: a loadable down-counter with a zero flag, instantiated once.

## Test plan
- SRAM_DW=16, RD_WAIT=1: read from 0x00010 with sel=1111 → SRAM words 0x00008 then 0x00009 are read; ack in cycle 9; wb_dat_o = {word9, word8}.
- SRAM_DW=16, WR_WAIT=2: write 0xA5A5_1234 with sel=1100 → one beat at word addr+1; be_n=00; we_n low for exactly 3 cycles; ack in cycle 6.
- sel=0000 on a read → no ce_n activity; ack in cycle 1; wb_dat_o=0.
- SRAM_DW=8: write 0xDDCCBBAA with sel=0101 → two beats at byte addrs +0 and +2 with data 0xAA and 0xCC; ack in cycle 1+2·(3+WR_WAIT).
- Reset low during a write's ACCESS → we_n=1 and dq hi-Z at the next edge; no ack; next transfer completes normally.
- cyc_i dropped in beat 0's ACCESS of a 2-beat read → beat 0 completes its HOLD; no ack; beat 1 is never strobed; the FSM is back in IDLE.
